// File: rtl/button_conditioner.sv
// Per-channel push-button front-end: synchroniser, debounce FSM and registered
// press/release/long-press strobes with a clean debounced level.
module button_conditioner #(
    parameter int unsigned NUM_BTN           = 3,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 120000,
    parameter int unsigned LONG_PRESS_CYCLES = 12000000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDbPress,
        StPressed,
        StDbRelease
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q [NUM_BTN];
    logic [NUM_BTN-1:0]     s;

    state_e             state_q [NUM_BTN];
    state_e             state_d [NUM_BTN];
    logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
    logic [HOLD_W-1:0]  hold_q  [NUM_BTN];
    logic [HOLD_W-1:0]  hold_d  [NUM_BTN];

    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] press_d;
    logic [NUM_BTN-1:0] release_d;
    logic [NUM_BTN-1:0] long_d;

    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            hold_d[i]    = hold_q[i];
            level_d[i]   = btn_level[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            long_d[i]    = 1'b0;

            // Hold keeps running through a release glitch so long-press timing is unaffected.
            if ((state_q[i] == StPressed || state_q[i] == StDbRelease) &&
                hold_q[i] < HOLD_MAX) begin
                hold_d[i] = hold_q[i] + HOLD_W'(1);
                long_d[i] = (hold_q[i] == HOLD_LAST);
            end

            unique case (state_q[i])
                StIdle: begin
                    if (s[i]) begin
                        state_d[i] = StDbPress;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                StDbPress: begin
                    if (!s[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i]  = StPressed;
                        cnt_d[i]    = '0;
                        hold_d[i]   = '0;
                        press_d[i]  = 1'b1;
                        level_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                StPressed: begin
                    if (!s[i]) begin
                        state_d[i] = StDbRelease;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                StDbRelease: begin
                    if (s[i]) begin
                        state_d[i] = StPressed;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i]   = StIdle;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
                        level_d[i]   = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_long    <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                hold_q[i]  <= hold_d[i];
            end
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            btn_long    <= long_d;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected strobe events
// (cycle + outputs), a negedge monitor pops and compares whenever a strobe appears.
module tb_button_conditioner;

    localparam int unsigned NB = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;

    button_conditioner #(
        .NUM_BTN          (NB),
        .SYNC_STAGES      (2),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        int unsigned   cyc;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] lng;
        logic [NB-1:0] lvl;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic push(input int unsigned c, input logic [NB-1:0] p, input logic [NB-1:0] r,
                        input logic [NB-1:0] l, input logic [NB-1:0] lv);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.lvl = lv;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_vec(input string name, input logic [4*NB-1:0] act,
                             input logic [4*NB-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: any strobe must match the oldest expectation, at the expected cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: expected at cycle %0d, still pending at cycle %0d",
                         exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (|{btn_press, btn_release, btn_long}) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got p=%b r=%b l=%b at cycle %0d, none expected",
                             btn_press, btn_release, btn_long, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc) begin
                        errors++;
                        $display("FAIL event_cycle: got cycle %0d expected %0d", cyc, mon_e.cyc);
                    end
                    check_vec("event_outputs", {btn_press, btn_release, btn_long, btn_level},
                              {mon_e.press, mon_e.rel, mon_e.lng, mon_e.lvl});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int unsigned n;

    initial begin
        RST     = 1'b1;
        btn_raw = '0;
        wait_cyc(3);
        check_vec("reset_outputs", {btn_press, btn_release, btn_long, btn_level}, '0);
        RST = 1'b0;
        wait_cyc(3);

        // 1: clean press/release on ch0
        n = cyc; btn_raw[0] = 1'b1;
        push(n + 6, 3'b001, 3'b000, 3'b000, 3'b001);
        wait_cyc(8);
        n = cyc; btn_raw[0] = 1'b0;
        push(n + 6, 3'b000, 3'b001, 3'b000, 3'b000);
        wait_cyc(12);

        // 2: bounce on ch1 must produce nothing
        btn_raw[1] = 1'b1; wait_cyc(3);
        btn_raw[1] = 1'b0; wait_cyc(1);
        btn_raw[1] = 1'b1; wait_cyc(3);
        btn_raw[1] = 1'b0; wait_cyc(12);
        check_vec("bounce_level", {9'b0, btn_level}, '0);

        // 3: long press on ch2
        n = cyc; btn_raw[2] = 1'b1;
        push(n + 6,  3'b100, 3'b000, 3'b000, 3'b100);
        push(n + 22, 3'b000, 3'b000, 3'b100, 3'b100);
        wait_cyc(40);
        n = cyc; btn_raw[2] = 1'b0;
        push(n + 6, 3'b000, 3'b100, 3'b000, 3'b000);
        wait_cyc(12);

        // 4: release glitch on ch0 while pressed
        n = cyc; btn_raw[0] = 1'b1;
        push(n + 6,  3'b001, 3'b000, 3'b000, 3'b001);
        push(n + 22, 3'b000, 3'b000, 3'b001, 3'b001);
        wait_cyc(10);
        btn_raw[0] = 1'b0; wait_cyc(2);
        btn_raw[0] = 1'b1; wait_cyc(4);
        check_vec("glitch_level", {9'b0, btn_level}, {9'b0, 3'b001});
        wait_cyc(14);
        n = cyc; btn_raw[0] = 1'b0;
        push(n + 6, 3'b000, 3'b001, 3'b000, 3'b000);
        wait_cyc(12);

        // 5: async reset while ch0 pressed, button still held afterwards
        n = cyc; btn_raw[0] = 1'b1;
        push(n + 6, 3'b001, 3'b000, 3'b000, 3'b001);
        wait_cyc(10);
        check_vec("pre_reset_level", {9'b0, btn_level}, {9'b0, 3'b001});
        #2 RST = 1'b1;
        #1 check_vec("async_reset", {btn_press, btn_release, btn_long, btn_level}, '0);
        wait_cyc(2);
        RST = 1'b0;
        n = cyc;
        push(n + 6, 3'b001, 3'b000, 3'b000, 3'b001);
        wait_cyc(10);
        n = cyc; btn_raw[0] = 1'b0;
        push(n + 6, 3'b000, 3'b001, 3'b000, 3'b000);
        wait_cyc(12);

        // 6: simultaneous press/release on all channels
        n = cyc; btn_raw = 3'b111;
        push(n + 6, 3'b111, 3'b000, 3'b000, 3'b111);
        wait_cyc(8);
        n = cyc; btn_raw = 3'b000;
        push(n + 6, 3'b000, 3'b111, 3'b000, 3'b000);
        wait_cyc(12);

        wait_cyc(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending events expected 0", exp_q.size());
        end
        check_vec("final_outputs", {btn_press, btn_release, btn_long, btn_level}, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
